// File: rtl/unified_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// unified_mem_arb_pkg
// Shared types and constants for the unified instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   arb_owner_t : owner of the current transaction (OWN_I=0, OWN_D=1)
//   LAT_CNT_W   : width of the memory latency counter
//   STREAK_W    : width of the consecutive-data-grant streak counter
// -----------------------------------------------------------------------------
package unified_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int LAT_CNT_W = 4;
    localparam int STREAK_W  = 4;

endpackage

// File: rtl/unified_mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational grant selection for the unified memory arbiter.
// Ports:
//   i_ireq    : instruction fetch pending
//   i_dreq    : data access pending
//   i_starved : fetch has waited through the tolerated number of data grants
//   o_any     : some requester is pending
//   o_owner   : winner (data unless only fetch pends, or fetch is starved)
// -----------------------------------------------------------------------------
module mem_arb_pick
    import unified_mem_arb_pkg::*;
(
    input  logic       i_ireq,
    input  logic       i_dreq,
    input  logic       i_starved,
    output logic       o_any,
    output arb_owner_t o_owner
);

    assign o_any   = i_ireq | i_dreq;
    assign o_owner = (i_dreq && !(i_ireq && i_starved)) ? OWN_D : OWN_I;

endmodule

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Serialises instruction-fetch and data accesses onto one single-port memory
// with a fixed read latency. Each access runs IDLE -> ISSUE -> WAIT x MEM_LAT
// -> RESP and returns a one-cycle ack plus read data to its requester.
// Data has priority; with UNIFIED_MEM_ARB_FAIRNESS_EN defined, a streak
// counter forces a fetch grant after STARVE_MAX consecutive data grants made
// while a fetch was waiting.
// Ports:
//   clk, reset             : clock, synchronous active-low reset
//   i_req, i_addr          : fetch request / address
//   i_ack, i_rdata         : fetch complete pulse / fetched word
//   d_cs, d_r, d_w         : data chip-select, read, write (write wins)
//   d_addr, d_wdata        : data address / store data
//   d_ack, d_rdata         : data complete pulse / load data (0 on writes)
//   mem_en, mem_we         : memory strobe (one cycle) / write enable
//   mem_addr, mem_wdata    : memory address / write data (held ISSUE..RESP)
//   mem_rdata              : memory read data, valid MEM_LAT cycles after mem_en
//   busy                   : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module unified_mem_arbiter
    import unified_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_cs,
    input  logic              d_r,
    input  logic              d_w,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT   = LAT_CNT_W'(MEM_LAT);
    localparam logic [STREAK_W-1:0]  STARVE_LIM = STREAK_W'(STARVE_MAX);

    arb_state_t          r_state;
    arb_owner_t          r_owner;
    logic [LAT_CNT_W-1:0] r_cnt;
    logic                r_i_ack, r_d_ack, r_mem_en, r_mem_we, r_busy;
    logic [DATA_W-1:0]   r_i_rdata, r_d_rdata, r_mem_wdata;
    logic [ADDR_W-1:0]   r_mem_addr;

    logic                w_d_req, w_any, w_starved;
    logic [STREAK_W-1:0] w_streak;
    arb_owner_t          w_owner;

    assign w_d_req = d_cs & (d_r | d_w);

`ifdef UNIFIED_MEM_ARB_FAIRNESS_EN
    logic [STREAK_W-1:0] r_streak;

    // Counts data grants that overtook a waiting fetch; any fetch grant, or a
    // data grant with no fetch waiting, ends the streak.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_streak <= '0;
        end else if (r_state == IDLE && w_any) begin
            if (w_owner == OWN_D && i_req) r_streak <= r_streak + 1'b1;
            else                           r_streak <= '0;
        end
    end
    assign w_streak = r_streak;
`else
    // Strict data priority: the streak is pinned at zero, which never matches
    // a legal STARVE_MAX, so the guard folds away.
    assign w_streak = '0;
`endif

    assign w_starved = (w_streak == STARVE_LIM);

    mem_arb_pick u_pick (
        .i_ireq    (i_req),
        .i_dreq    (w_d_req),
        .i_starved (w_starved),
        .o_any     (w_any),
        .o_owner   (w_owner)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_I;
            r_cnt       <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_mem_en <= 1'b0;
            r_i_ack  <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state  <= ISSUE;
                        r_owner  <= w_owner;
                        r_mem_en <= 1'b1;
                        r_busy   <= 1'b1;
                        if (w_owner == OWN_D) begin
                            r_mem_addr  <= d_addr;
                            r_mem_we    <= d_w;
                            r_mem_wdata <= d_wdata;
                        end else begin
                            r_mem_addr  <= i_addr;
                            r_mem_we    <= 1'b0;
                            r_mem_wdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt   <= LAT_INIT;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    // Counter hits zero on this edge: mem_rdata is valid now.
                    if (r_cnt == LAT_CNT_W'(1)) begin
                        r_state <= RESP;
                        if (r_owner == OWN_D) begin
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= r_mem_we ? '0 : mem_rdata;
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_we    <= 1'b0;
                    r_mem_wdata <= '0;
                    r_i_rdata   <= '0;
                    r_d_rdata   <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i_ack     = r_i_ack;
    assign i_rdata   = r_i_rdata;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomised bench: two protocol-following requesters, a latency-accurate
// memory, and a transaction-schedule reference model that predicts every
// output per cycle from the grant time of the current access.
module tb_unified_mem_arbiter;
    localparam int AW = 32, DW = 32, LAT = 3, SMAX = 2, NCYC = 2000;

    logic clk = 1'b0, reset;
    logic i_req, i_ack, d_cs, d_r, d_w, d_ack, mem_en, mem_we, busy;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_cs(d_cs), .d_r(d_r), .d_w(d_w), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [DW-1:0] init_val(input int idx);
        if (idx == 16) return 32'h2408_0005;   // word at 0x40
        return DW'(idx) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
    endfunction

    // Environment memory: MEM_LAT-deep read pipe, junk when no read issued.
    logic [DW-1:0] env_mem [64];
    bit            env_wr  [64];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
        rd_pipe[0] <= (mem_en && !mem_we) ?
                      (env_wr[mem_addr[7:2]] ? env_mem[mem_addr[7:2]] : init_val(int'(mem_addr[7:2])))
                      : $urandom;
        if (mem_en && mem_we) begin
            env_mem[mem_addr[7:2]] <= mem_wdata;
            env_wr[mem_addr[7:2]]  <= 1'b1;
        end
    end
    assign mem_rdata = rd_pipe[LAT-1];

    int n_cmp = 0, n_bad = 0;
    int cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state: one access at a time, described by its grant cycle.
    logic [DW-1:0] ref_mem [64];
    bit            act, own_d, m_we, i_out, d_out, did_rst, ir, dr, pick_d, in_x, e_ack;
    int            g, free_at, streak, p_req, idx;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    task automatic drive();
        if (i_out) begin
        end else if ($urandom_range(0, 99) < p_req) begin
            i_out = 1; i_req = 1; i_addr = AW'($urandom_range(0, 63) * 4);
        end else begin
            i_req = 0; i_addr = $urandom;
        end
        if (d_out) begin
        end else if ($urandom_range(0, 99) < p_req) begin
            d_out = 1; d_cs = 1;
            case ($urandom_range(0, 2))
                0:       begin d_r = 1; d_w = 0; end
                1:       begin d_r = 0; d_w = 1; end
                default: begin d_r = 1; d_w = 1; end
            endcase
            d_addr = AW'($urandom_range(0, 63) * 4); d_wdata = $urandom;
        end else begin
            if ($urandom_range(0, 1) == 1) begin
                d_cs = 0; d_r = 1'($urandom_range(0, 1)); d_w = 1'($urandom_range(0, 1));
            end else begin
                d_cs = 1; d_r = 0; d_w = 0;
            end
            d_addr = $urandom; d_wdata = $urandom;
        end
    endtask

    task automatic check_cycle();
        in_x  = act && cyc >= g + 1 && cyc <= g + 2 + LAT;
        e_ack = act && cyc == g + 2 + LAT;
        chk("i_ack",    64'(i_ack),  64'(e_ack && !own_d));
        chk("d_ack",    64'(d_ack),  64'(e_ack && own_d));
        chk("mem_en",   64'(mem_en), 64'(act && cyc == g + 1));
        chk("mem_we",   64'(mem_we), 64'(in_x && m_we));
        chk("mem_addr", 64'(mem_addr), in_x ? 64'(m_addr) : 64'd0);
        chk("busy",     64'(busy),   64'(in_x));
        if (in_x && m_we)    chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        if (e_ack && !own_d) chk("i_rdata", 64'(i_rdata), 64'(m_rdata));
        if (e_ack && own_d)  chk("d_rdata", 64'(d_rdata), m_we ? 64'd0 : 64'(m_rdata));
    endtask

    task automatic model_step();
        if (!reset) begin
            act = 0; free_at = cyc + 1; streak = 0;
            return;
        end
        if (act && cyc == g + 2 + LAT) begin
            act = 0;
            if (own_d) d_out = 0; else i_out = 0;
        end
        if (cyc < free_at) return;
        ir = i_req;
        dr = d_cs && (d_r || d_w);
        if (!(ir || dr)) return;
        pick_d = dr;
`ifdef UNIFIED_MEM_ARB_FAIRNESS_EN
        if (ir && dr && streak == SMAX) pick_d = 0;
        streak = (pick_d && ir) ? streak + 1 : 0;
`endif
        act = 1; g = cyc; own_d = pick_d; free_at = cyc + 3 + LAT;
        if (own_d) begin
            m_addr = d_addr; m_we = d_w; m_wdata = d_wdata;
        end else begin
            m_addr = i_addr; m_we = 0; m_wdata = '0;
        end
        idx = int'(m_addr[7:2]);
        if (m_we) ref_mem[idx] = m_wdata;
        m_rdata = ref_mem[idx];
    endtask

    initial begin
        for (int k = 0; k < 64; k++) ref_mem[k] = init_val(k);
        reset = 0; i_req = 0; i_addr = '0; d_cs = 0; d_r = 0; d_w = 0;
        d_addr = '0; d_wdata = '0;
        act = 0; i_out = 0; d_out = 0; did_rst = 0; streak = 0; free_at = 0; g = 0;
        cyc = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_i_ack",    64'(i_ack),    64'd0);
        chk("rst_d_ack",    64'(d_ack),    64'd0);
        chk("rst_mem_en",   64'(mem_en),   64'd0);
        chk("rst_mem_we",   64'(mem_we),   64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata",64'(mem_wdata),64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_i_rdata",  64'(i_rdata),  64'd0);
        chk("rst_d_rdata",  64'(d_rdata),  64'd0);
        @(posedge clk); #1;
        for (cyc = 0; cyc < NCYC; cyc++) begin
            p_req = (cyc < 700) ? 50 : (cyc < 1400) ? 100 : 25;
            drive();
            // Abort an access mid-WAIT: once for sure, occasionally at random.
            if (act && cyc == g + 2 &&
                ((!did_rst && cyc >= 300) || $urandom_range(0, 59) == 0)) begin
                reset = 0; did_rst = 1;
            end else begin
                reset = 1;
            end
            @(negedge clk);
            check_cycle();
            model_step();
            @(posedge clk); #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
